conv_sched: RTL
===============

Name: conv_sched

Overview:
- Scheduler between the image controller's pixel stream and the floating-point multiplier array.
- Loads a K_DIM x K_DIM kernel from a weight stream into a local register file.
- For every incoming pixel, issues all K_SIZE (pixel, weight, output-coordinate) products to M_CNT parallel multiplier lanes, in ceil(K_SIZE/M_CNT) batches.
- Output coordinates address the full-convolution output plane (O_DIM x O_DIM).

Parameters:
- K_DIM, 3, kernel dimension.
- I_DIM, 8, image dimension.
- M_BITS, 16, floating-point word width (data treated as opaque bits).
- M_CNT, 4, number of multiplier lanes.
- K_SIZE, K_DIM*K_DIM, kernel taps (derived).
- B_CNT, ceil(K_SIZE/M_CNT), batches per pixel (derived; 3 at defaults).
- I_BITS, clog2(I_DIM), pixel coordinate width (derived; 3).
- O_DIM, K_DIM+I_DIM-1, output dimension (derived; 10).
- O_BITS, clog2(O_DIM), output coordinate width (derived; 4).

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- k_data  in  M_BITS  kernel weight, row-major tap order
- k_valid  in  1  weight valid
- k_last  in  1  final weight of the kernel
- k_ready  out  1  weight accepted when k_valid&&k_ready
- img_data  in  M_BITS  pixel value
- img_user  in  2*I_BITS  {row, col} of the pixel, row in MSBs
- img_last  in  1  final pixel of the image
- img_valid  in  1  pixel valid
- img_ready  out  1  pixel accepted when img_valid&&img_ready
- out_pix  out  M_BITS  held pixel, shared by all lanes
- out_wgt  out  M_CNT*M_BITS  per-lane weight, lane 0 in LSBs
- out_user  out  M_CNT*2*O_BITS  per-lane {orow, ocol}, lane 0 in LSBs
- out_lane_en  out  M_CNT  lane carries a valid tap
- out_last  out  1  final batch of the final pixel
- out_valid  out  1  batch valid
- out_ready  in  1  multiplier array accepts the batch
- done  out  1  one-cycle pulse, image complete
- k_err  out  1  sticky flag, kernel length mismatch

Behaviour:
- Reset values: state LOAD; weight regs, tap counter, batch index, pixel hold regs, out_valid, img_ready, done, k_err, out_last all 0. k_ready = 1 (derived from LOAD).
- Outputs other than k_ready and img_ready are registered.
- LOAD:
  - k_ready=1, img_ready=0; each accepted weight is written to tap k_idx, then k_idx increments.
  - Accept with k_last and k_idx==K_SIZE-1 -> RUN.
  - k_last with k_idx<K_SIZE-1 -> remaining taps forced to 0, k_err=1, go to RUN.
  - K_SIZE-th accept without k_last -> k_err=1, go to RUN. Further weights are not accepted until the next LOAD.
- RUN: k_ready=0, img_ready=1. An accepted pixel captures data, {row,col} and img_last, sets b=0 and goes to ISSUE. out_valid rises the cycle after acceptance (latency 1).
- ISSUE, batch b:
  - Lane l carries tap t = b*M_CNT + l.
  - out_lane_en[l] = (t < K_SIZE). Disabled lanes drive wgt=0 and user=0.
  - kr = t / K_DIM, kc = t % K_DIM; orow = row + kr, ocol = col + kc, zero-extended to O_BITS (never overflows).
  - out_valid and all payload hold stable while !out_ready.
  - out_ready on b<B_CNT-1 -> b+1.
- Last batch (b==B_CNT-1):
  - out_last = held img_last.
  - img_ready = out_ready && !held img_last. A pixel accepted in the same cycle loads directly into batch 0, so there are no bubbles and throughput is B_CNT cycles/pixel.
  - Accepted with held img_last=0 and no new pixel -> RUN, out_valid=0.
  - Accepted with held img_last=1 -> done=1 for the next cycle, state LOAD, k_idx=0. Weights are retained until overwritten. k_err is cleared on the first weight accept in LOAD.
- img_last is not required to coincide with coordinate (I_DIM-1, I_DIM-1); no check is made.
- Asynchronous reset mid-operation aborts any batch, clears weights, and returns to LOAD. Partially issued pixels are not replayed.

Decomposition:
- Package conv_pkg holds:
  - state enum {LOAD, RUN, ISSUE};
  - the derived-width functions (clog2, ceil-div);
  - a constant function returning tap-to-(kr,kc) offsets as a K_SIZE-entry table, so there is no runtime divider.
- One sub-module, conv_tap_map: combinational per-lane mapping of (b, row, col) to lane_en/orow/ocol, instantiated M_CNT times by generate.

Test Plan:
- Weights 0x0001..0x0009 with k_last on the 9th, then pixel 0x3C00 at (2,5):
  - batch0 users (2,5),(2,6),(2,7),(3,5), wgts 1-4, en=1111;
  - batch1 users (3,6),(3,7),(4,5),(4,6), wgts 5-8;
  - batch2 user (4,7), wgt 9, en=0001.
- k_last on the 5th weight -> k_err=1; batches for a pixel show taps 5-8 with wgt 0; k_err clears on the next kernel's first weight.
- out_ready low 4 cycles during batch1 -> payload stable, no batch skipped or repeated; out_ready toggling every cycle -> exact sequence b=0,1,2.
- 64 back-to-back pixels, out_ready=1 -> 192 consecutive valid batches, img_ready high exactly on each batch2 cycle.
- Pixel (7,7) with img_last=1 -> out_last only on its batch2, (9,9) appears on lane 0; done pulses 1 cycle; img_ready=0 and k_ready=1 afterwards.
- rstn low during batch1 -> out_valid=0, k_ready=1, weights 0; a new kernel and pixel then run correctly.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared state type and elaboration-time helpers for the convolution scheduler.
// The tap offset table is computed once at elaboration so no divider exists in hardware.
package conv_pkg;

   typedef enum logic [1:0] {LOAD, RUN, ISSUE} state_t;

   localparam int MAX_TAPS = 64;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return (r < 1) ? 1 : r;
   endfunction

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

   // Entry t holds {kr, kc} as two bytes, tap 0 in the LSBs.
   function automatic logic [MAX_TAPS*16-1:0] tap_offsets(input int k_dim);
      logic [MAX_TAPS*16-1:0] tab;
      tab = '0;
      for (int t = 0; t < MAX_TAPS; t++) begin
         if (t < k_dim * k_dim) begin
            tab[t*16 +: 8]     = 8'(t % k_dim);
            tab[t*16 + 8 +: 8] = 8'(t / k_dim);
         end
      end
      return tab;
   endfunction

endpackage

// File: rtl/conv_tap_map.sv
// Maps a batch index and pixel coordinate to one lane's tap number and
// output coordinate, using constant per-batch offsets for this lane.
module conv_tap_map
   import conv_pkg::*;
#(
   parameter int K_DIM  = 3,
   parameter int M_CNT  = 4,
   parameter int LANE   = 0,
   parameter int I_BITS = 3,
   parameter int O_BITS = 4,
   parameter int B_BITS = 2,
   parameter int T_BITS = 4
) (
   input  logic [B_BITS-1:0] b,
   input  logic [I_BITS-1:0] row,
   input  logic [I_BITS-1:0] col,
   output logic              lane_en,
   output logic [T_BITS-1:0] tap,
   output logic [O_BITS-1:0] orow,
   output logic [O_BITS-1:0] ocol
);

   localparam int K_SIZE = K_DIM * K_DIM;
   localparam int B_CNT  = ceil_div(K_SIZE, M_CNT);
   localparam logic [MAX_TAPS*16-1:0] OFF_TAB = tap_offsets(K_DIM);

   logic [B_CNT-1:0]  en_tab;
   logic [T_BITS-1:0] tap_tab [B_CNT];
   logic [O_BITS-1:0] kr_tab  [B_CNT];
   logic [O_BITS-1:0] kc_tab  [B_CNT];

   for (genvar gi = 0; gi < B_CNT; gi++) begin : g_batch
      localparam int T = gi * M_CNT + LANE;
      if (T < K_SIZE) begin : g_on
         localparam logic [15:0] OFF = OFF_TAB[T*16 +: 16];
         assign en_tab[gi]  = 1'b1;
         assign tap_tab[gi] = T_BITS'(T);
         assign kr_tab[gi]  = O_BITS'(OFF[15:8]);
         assign kc_tab[gi]  = O_BITS'(OFF[7:0]);
      end else begin : g_off
         assign en_tab[gi]  = 1'b0;
         assign tap_tab[gi] = '0;
         assign kr_tab[gi]  = '0;
         assign kc_tab[gi]  = '0;
      end
   end

   always_comb begin
      lane_en = 1'b0;
      tap     = '0;
      orow    = '0;
      ocol    = '0;
      if (int'(b) < B_CNT && en_tab[b]) begin
         lane_en = 1'b1;
         tap     = tap_tab[b];
         orow    = O_BITS'(row) + kr_tab[b];
         ocol    = O_BITS'(col) + kc_tab[b];
      end
   end

endmodule

// File: rtl/conv_sched.sv
// Kernel loader and per-pixel batch issuer feeding M_CNT multiplier lanes.
// The next batch payload is computed from the next-state values and registered.
module conv_sched
   import conv_pkg::*;
#(
   parameter  int K_DIM  = 3,
   parameter  int I_DIM  = 8,
   parameter  int M_BITS = 16,
   parameter  int M_CNT  = 4,
   localparam int K_SIZE = K_DIM * K_DIM,
   localparam int B_CNT  = ceil_div(K_SIZE, M_CNT),
   localparam int I_BITS = clog2(I_DIM),
   localparam int O_DIM  = K_DIM + I_DIM - 1,
   localparam int O_BITS = clog2(O_DIM)
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic [M_BITS-1:0]          k_data,
   input  logic                       k_valid,
   input  logic                       k_last,
   output logic                       k_ready,
   input  logic [M_BITS-1:0]          img_data,
   input  logic [2*I_BITS-1:0]        img_user,
   input  logic                       img_last,
   input  logic                       img_valid,
   output logic                       img_ready,
   output logic [M_BITS-1:0]          out_pix,
   output logic [M_CNT*M_BITS-1:0]    out_wgt,
   output logic [M_CNT*2*O_BITS-1:0]  out_user,
   output logic [M_CNT-1:0]           out_lane_en,
   output logic                       out_last,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       done,
   output logic                       k_err
);

   localparam int B_BITS  = clog2(B_CNT);
   localparam int KI_BITS = clog2(K_SIZE + 1);
   localparam int T_BITS  = clog2(K_SIZE);
   localparam logic [B_BITS-1:0]  B_LAST = B_BITS'(B_CNT - 1);
   localparam logic [KI_BITS-1:0] K_LAST = KI_BITS'(K_SIZE - 1);

   state_t                    state_q, state_d;
   logic [M_BITS-1:0]         kw_q [K_SIZE];
   logic [M_BITS-1:0]         kw_d [K_SIZE];
   logic [KI_BITS-1:0]        k_idx_q, k_idx_d;
   logic [B_BITS-1:0]         b_q, b_d;
   logic [M_BITS-1:0]         pix_q, pix_d;
   logic [I_BITS-1:0]         row_q, row_d, col_q, col_d;
   logic                      last_q, last_d;
   logic                      k_err_q, k_err_d;
   logic                      done_q, done_d;
   logic                      out_valid_q, out_valid_d;
   logic                      out_last_q, out_last_d;
   logic [M_CNT*M_BITS-1:0]   out_wgt_q, out_wgt_d;
   logic [M_CNT*2*O_BITS-1:0] out_user_q, out_user_d;
   logic [M_CNT-1:0]          out_lane_en_q, out_lane_en_d;

   assign k_ready   = (state_q == LOAD);
   // A new pixel may be taken while the final batch of the current one leaves.
   assign img_ready = (state_q == RUN) ||
                      (state_q == ISSUE && b_q == B_LAST && out_ready && !last_q);

   always_comb begin
      state_d     = state_q;
      kw_d        = kw_q;
      k_idx_d     = k_idx_q;
      b_d         = b_q;
      pix_d       = pix_q;
      row_d       = row_q;
      col_d       = col_q;
      last_d      = last_q;
      k_err_d     = k_err_q;
      done_d      = 1'b0;
      out_valid_d = out_valid_q;
      unique case (state_q)
         LOAD: begin
            if (k_valid) begin
               kw_d[k_idx_q] = k_data;
               k_idx_d       = k_idx_q + KI_BITS'(1);
               if (k_idx_q == '0) k_err_d = 1'b0;
               if (k_idx_q == K_LAST) begin
                  state_d = RUN;
                  if (!k_last) k_err_d = 1'b1;
               end else if (k_last) begin
                  state_d = RUN;
                  k_err_d = 1'b1;
                  for (int i = 0; i < K_SIZE; i++)
                     if (i > int'(k_idx_q)) kw_d[i] = '0;
               end
            end
         end
         RUN: ;
         ISSUE: begin
            if (out_ready) begin
               if (b_q != B_LAST) begin
                  b_d = b_q + B_BITS'(1);
               end else if (last_q) begin
                  state_d     = LOAD;
                  k_idx_d     = '0;
                  done_d      = 1'b1;
                  out_valid_d = 1'b0;
               end else begin
                  state_d     = RUN;
                  out_valid_d = 1'b0;
               end
            end
         end
         default: state_d = LOAD;
      endcase
      if (img_valid && img_ready) begin
         pix_d       = img_data;
         row_d       = img_user[2*I_BITS-1 -: I_BITS];
         col_d       = img_user[I_BITS-1:0];
         last_d      = img_last;
         b_d         = '0;
         state_d     = ISSUE;
         out_valid_d = 1'b1;
      end
   end

   assign out_last_d = (state_d == ISSUE) && (b_d == B_LAST) && last_d;

   for (genvar gi = 0; gi < M_CNT; gi++) begin : g_lane
      logic              en;
      logic [T_BITS-1:0] tap;
      logic [O_BITS-1:0] orow, ocol;

      conv_tap_map #(
         .K_DIM (K_DIM),
         .M_CNT (M_CNT),
         .LANE  (gi),
         .I_BITS(I_BITS),
         .O_BITS(O_BITS),
         .B_BITS(B_BITS),
         .T_BITS(T_BITS)
      ) u_map (
         .b      (b_d),
         .row    (row_d),
         .col    (col_d),
         .lane_en(en),
         .tap    (tap),
         .orow   (orow),
         .ocol   (ocol)
      );

      assign out_lane_en_d[gi]                      = en;
      assign out_wgt_d[gi*M_BITS +: M_BITS]         = en ? kw_q[tap] : '0;
      assign out_user_d[gi*2*O_BITS +: 2*O_BITS]    = {orow, ocol};
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= LOAD;
         kw_q          <= '{default: '0};
         k_idx_q       <= '0;
         b_q           <= '0;
         pix_q         <= '0;
         row_q         <= '0;
         col_q         <= '0;
         last_q        <= 1'b0;
         k_err_q       <= 1'b0;
         done_q        <= 1'b0;
         out_valid_q   <= 1'b0;
         out_last_q    <= 1'b0;
         out_wgt_q     <= '0;
         out_user_q    <= '0;
         out_lane_en_q <= '0;
      end else begin
         state_q       <= state_d;
         kw_q          <= kw_d;
         k_idx_q       <= k_idx_d;
         b_q           <= b_d;
         pix_q         <= pix_d;
         row_q         <= row_d;
         col_q         <= col_d;
         last_q        <= last_d;
         k_err_q       <= k_err_d;
         done_q        <= done_d;
         out_valid_q   <= out_valid_d;
         out_last_q    <= out_last_d;
         out_wgt_q     <= out_wgt_d;
         out_user_q    <= out_user_d;
         out_lane_en_q <= out_lane_en_d;
      end
   end

   assign out_pix     = pix_q;
   assign out_wgt     = out_wgt_q;
   assign out_user    = out_user_q;
   assign out_lane_en = out_lane_en_q;
   assign out_last    = out_last_q;
   assign out_valid   = out_valid_q;
   assign done        = done_q;
   assign k_err       = k_err_q;

endmodule
